rv32i_fetch_stage: RTL and testbench
====================================

Name: rv32i_fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline: owns the fetch PC and issues in-order requests to instruction memory.
- Buffers returned words in a small fetch queue and drives the IF/DEC pipeline register.
- Consumes the hazard unit's pc_stall/dec_stall/dec_flush and the MEM-stage branch redirect.
- Decode reads instr/pc from this block.

Parameters:
- ADDR_WTH, 32, PC/address width
- WORD_WTH, 32, instruction width
- FQ_DEPTH, 2, fetch-queue entries and maximum outstanding requests (power of 2, at least 2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- pc_stall_i  in  1  suppress new fetch requests this cycle
- dec_stall_i  in  1  hold the IF/DEC register
- dec_flush_i  in  1  bubble the IF/DEC register
- br_taken_i  in  1  redirect from MEM stage
- br_target_i  in  ADDR_WTH  redirect address; bits [1:0] are ignored (forced to 0)
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  ADDR_WTH  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid (in order, latency ≥1 cycle after gnt)
- imem_rdata_i  in  WORD_WTH  response instruction
- dec_valid_o  out  1  IF/DEC register holds a live instruction
- dec_instr_o  out  WORD_WTH  instruction to decode
- dec_pc_o  out  ADDR_WTH  PC of dec_instr_o
- dec_pc_plus4_o  out  ADDR_WTH  dec_pc_o + 4

Behaviour:
Reset
- rst_n_i low, asynchronous: fetch_pc = RESET_PC; queue, outstanding count and drop count = 0.
- Outputs: imem_req_o = 0, dec_valid_o = 0, dec_instr_o = NOP (32'h0000_0013), dec_pc_o = 0, dec_pc_plus4_o = 4.
- First request may assert in the first cycle after reset release.
- Reset mid-transaction abandons all outstanding responses. The memory model must also be reset.

Issue
- imem_req_o = !br_taken_i && !pc_stall_i && (outstanding + fq_count < FQ_DEPTH).
- imem_addr_o = fetch_pc, combinational from the register.
- On req && gnt: fetch_pc += 4 (wraps modulo 2^ADDR_WTH); outstanding += 1.
- No grant: address holds.
- Requests may be withdrawn only by br_taken_i or pc_stall_i.

Response
- On rvalid with drop_cnt > 0: discard the word and decrement drop_cnt.
- Otherwise: push {pc, instr} into the queue.
- Each request's PC is taken from a shadow PC that advances on every accepted response.
- outstanding -= 1 on every rvalid.
- A simultaneous gnt and rvalid leaves outstanding unchanged.

IF/DEC register (priority order)
1. dec_flush_i: dec_valid_o = 0, dec_instr_o = NOP, regardless of dec_stall_i.
2. dec_stall_i: hold all dec_* outputs.
3. Queue non-empty: pop head into the register, dec_valid_o = 1.
4. Queue empty and a non-dropped rvalid this cycle: bypass the response straight into the register (no queue write), dec_valid_o = 1.
5. Otherwise: dec_valid_o = 0, NOP.
- Latency: gnt at cycle N, rvalid at N+1 → dec_valid_o at N+2.

Redirect (br_taken_i)
- fetch_pc and shadow PC = {br_target_i[ADDR_WTH-1:2], 2'b00}; queue cleared.
- drop_cnt = outstanding − (1 if rvalid this cycle else 0). The response arriving in this cycle is itself discarded.
- Takes priority over pc_stall_i, which the hazard unit already masks.
- First target request may issue the following cycle.

Boundary rules
- Queue full: issue blocked by the credit rule, so overflow is impossible (assertion).
- Pop from empty never happens (assertion).
- Simultaneous push and pop on a full queue is legal.
- br_taken_i while dec_stall_i: dec_flush_i, asserted alongside by the hazard unit, wins.

Decomposition:
- Shared package rv32i_pkg: RV32I_NOP constant, default RESET_PC, ADDR_WTH/WORD_WTH defaults, and a fetch-entry struct {pc, instr}.
- One sub-module, rv32i_fetch_fifo: parameterised synchronous FIFO with push/pop/clear, count and full/empty flags, async active-low reset.
- The top holds the PC, credit/drop counters and the IF/DEC register.

Test Plan:
- Reset, then straight-line fetch with a 1-cycle memory → addresses 0x0, 0x4, 0x8…; dec_valid_o rises 2 cycles after release; dec_pc_o increments by 4 each cycle.
- Load-use stall: pc_stall_i = dec_stall_i = 1 for 1 cycle at dec_pc_o = 0x8 → req drops for that cycle; dec_pc_o holds 0x8 for 2 cycles; no instruction lost or duplicated.
- Branch with 2 outstanding (3-cycle memory): br_taken_i = 1, target 0x100 → both stale responses discarded; next dec_valid_o has dec_pc_o = 0x100 and the correct word; queue empty after redirect.
- gnt backpressure: imem_gnt_i low for 4 cycles → imem_addr_o stable at 0x10; then the fetch sequence continues 0x10, 0x14.
- Flush while stalled: dec_flush_i = 1 and dec_stall_i = 1 together → dec_valid_o = 0, dec_instr_o = 0x00000013 next cycle.
- Unaligned target 0x203 → imem_addr_o = 0x200. Fetch across 0xFFFF_FFFC → next address 0x0000_0000.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-queue entry type.
package rv32i_pkg;
  localparam int          ADDR_WTH_DFLT = 32;
  localparam int          WORD_WTH_DFLT = 32;
  localparam logic [31:0] RV32I_NOP     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_WTH_DFLT-1:0] pc;
    logic [WORD_WTH_DFLT-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Small synchronous FIFO with clear; power-of-2 depth so pointers wrap naturally.
module rv32i_fetch_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_wdata,
  input  logic                   i_pop,
  output logic [DATA_W-1:0]      o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_cnt;

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  // Push+pop on full writes the slot being read this edge; the read sees the old word.
  always_ff @(posedge clk_i) begin
    if (i_push && !i_clear) r_mem[r_wptr] <= i_wdata;
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(i_pop && o_empty));
  a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_n_i) !(i_push && o_full && !i_pop));
endmodule

// File: rtl/rv32i_fetch_stage.sv
// RV32I IF stage: fetch PC, credit-limited imem requests, fetch queue, IF/DEC register.
module rv32i_fetch_stage
  import rv32i_pkg::*;
#(
  parameter int                ADDR_WTH = ADDR_WTH_DFLT,
  parameter int                WORD_WTH = WORD_WTH_DFLT,
  parameter int                FQ_DEPTH = 2,
  parameter logic [ADDR_WTH-1:0] RESET_PC = RESET_PC_DFLT[ADDR_WTH-1:0]
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                pc_stall_i,
  input  logic                dec_stall_i,
  input  logic                dec_flush_i,
  input  logic                br_taken_i,
  input  logic [ADDR_WTH-1:0] br_target_i,
  output logic                imem_req_o,
  output logic [ADDR_WTH-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [WORD_WTH-1:0] imem_rdata_i,
  output logic                dec_valid_o,
  output logic [WORD_WTH-1:0] dec_instr_o,
  output logic [ADDR_WTH-1:0] dec_pc_o,
  output logic [ADDR_WTH-1:0] dec_pc_plus4_o
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int EW = ADDR_WTH + WORD_WTH;
  localparam logic [WORD_WTH-1:0] NOP = WORD_WTH'(RV32I_NOP);

  logic [ADDR_WTH-1:0] r_fetch_pc, r_shadow_pc, r_dec_pc;
  logic [WORD_WTH-1:0] r_dec_instr;
  logic                r_dec_valid;
  logic [CW-1:0]       r_outst, r_drop;

  logic [CW-1:0]       w_fq_cnt;
  logic [EW-1:0]       w_fq_head;
  logic [ADDR_WTH-1:0] w_br_pc;
  logic w_fire, w_rsp_live, w_push, w_pop, w_bypass, w_fq_full, w_fq_empty;

  assign w_br_pc     = {br_target_i[ADDR_WTH-1:2], 2'b00};
  // Credit rule: in-flight plus buffered never exceeds queue depth, so every response has a slot.
  assign imem_req_o  = rst_n_i && !br_taken_i && !pc_stall_i &&
                       ((r_outst + w_fq_cnt) < CW'(FQ_DEPTH));
  assign imem_addr_o = r_fetch_pc;
  assign w_fire      = imem_req_o && imem_gnt_i;
  assign w_rsp_live  = imem_rvalid_i && (r_drop == '0) && !br_taken_i;
  assign w_pop       = !dec_flush_i && !dec_stall_i && !w_fq_empty;
  assign w_bypass    = !dec_flush_i && !dec_stall_i && w_fq_empty && w_rsp_live;
  assign w_push      = w_rsp_live && !w_bypass;

  rv32i_fetch_fifo #(.DATA_W(EW), .DEPTH(FQ_DEPTH)) u_fq (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_clear (br_taken_i),
    .i_push  (w_push),
    .i_wdata ({r_shadow_pc, imem_rdata_i}),
    .i_pop   (w_pop),
    .o_rdata (w_fq_head),
    .o_count (w_fq_cnt),
    .o_full  (w_fq_full),
    .o_empty (w_fq_empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_pc  <= RESET_PC;
      r_shadow_pc <= RESET_PC;
      r_outst     <= '0;
      r_drop      <= '0;
    end else if (br_taken_i) begin
      // Everything still in flight after this cycle belongs to the wrong path.
      r_fetch_pc  <= w_br_pc;
      r_shadow_pc <= w_br_pc;
      r_outst     <= r_outst - CW'(imem_rvalid_i);
      r_drop      <= r_outst - CW'(imem_rvalid_i);
    end else begin
      if (w_fire)     r_fetch_pc  <= r_fetch_pc + ADDR_WTH'(4);
      if (w_rsp_live) r_shadow_pc <= r_shadow_pc + ADDR_WTH'(4);
      if (imem_rvalid_i && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      r_outst <= r_outst + CW'(w_fire) - CW'(imem_rvalid_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dec_valid <= 1'b0;
      r_dec_instr <= NOP;
      r_dec_pc    <= '0;
    end else if (dec_flush_i) begin
      r_dec_valid <= 1'b0;
      r_dec_instr <= NOP;
    end else if (!dec_stall_i) begin
      if (!w_fq_empty) begin
        r_dec_valid <= 1'b1;
        r_dec_pc    <= w_fq_head[EW-1:WORD_WTH];
        r_dec_instr <= w_fq_head[WORD_WTH-1:0];
      end else if (w_bypass) begin
        r_dec_valid <= 1'b1;
        r_dec_pc    <= r_shadow_pc;
        r_dec_instr <= imem_rdata_i;
      end else begin
        r_dec_valid <= 1'b0;
        r_dec_instr <= NOP;
      end
    end
  end

  assign dec_valid_o    = r_dec_valid;
  assign dec_instr_o    = r_dec_instr;
  assign dec_pc_o       = r_dec_pc;
  assign dec_pc_plus4_o = r_dec_pc + ADDR_WTH'(4);

  a_fq_credit: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                !(w_push && w_fq_full && !w_pop));
endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Randomized bench: in-order memory model plus a program-order reference for fetch and decode.
module tb_rv32i_fetch_stage;
  import rv32i_pkg::*;
  localparam int FQ = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pc_stall = 0, dec_stall = 0, dec_flush = 0, br_taken = 0;
  logic [31:0] br_target = '0;
  logic        req, gnt = 0, rvalid = 0;
  logic [31:0] addr, rdata = '0;
  logic        dvalid;
  logic [31:0] dinstr, dpc, dpc4;

  rv32i_fetch_stage #(.ADDR_WTH(32), .WORD_WTH(32), .FQ_DEPTH(FQ), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pc_stall_i(pc_stall), .dec_stall_i(dec_stall),
    .dec_flush_i(dec_flush), .br_taken_i(br_taken), .br_target_i(br_target),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .dec_valid_o(dvalid), .dec_instr_o(dinstr), .dec_pc_o(dpc),
    .dec_pc_plus4_o(dpc4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  int          cyc = 0, n_chk = 0, n_err = 0;
  logic [31:0] exp_pc, exp_fetch, held_pc, held_instr;
  logic        held_valid, last_stall, last_flush;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; pc_stall = 0; dec_stall = 0; dec_flush = 0; br_taken = 0; gnt = 0; rvalid = 0;
    pend.delete();
    #1;
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_valid", {31'b0, dvalid}, 0);
    chk("rst_instr", dinstr, RV32I_NOP);
    chk("rst_pc", dpc, 0);
    chk("rst_pc4", dpc4, 4);
    @(negedge clk);
    rst_n = 1;
    exp_pc = 0; exp_fetch = 0; last_stall = 0; last_flush = 0;
  endtask

  // One cycle, entered at a negedge: check the IF/DEC register, drive inputs, score the request.
  task automatic cycle(input logic pst, input logic dst, input logic fl, input logic br,
                       input logic [31:0] tgt, input logic g, input int lat);
    if (last_flush) begin
      chk("flush_valid", {31'b0, dvalid}, 0);
      chk("flush_instr", dinstr, RV32I_NOP);
    end else if (last_stall) begin
      chk("hold_valid", {31'b0, dvalid}, {31'b0, held_valid});
      chk("hold_pc", dpc, held_pc);
      chk("hold_instr", dinstr, held_instr);
    end else if (dvalid) begin
      chk("dec_pc", dpc, exp_pc);
      chk("dec_instr", dinstr, memw(exp_pc));
      chk("dec_pc4", dpc4, exp_pc + 32'd4);
      exp_pc += 32'd4;
    end else begin
      chk("bubble_instr", dinstr, RV32I_NOP);
    end
    held_valid = dvalid; held_pc = dpc; held_instr = dinstr;

    pc_stall = pst; dec_stall = dst; dec_flush = fl; br_taken = br; br_target = tgt; gnt = g;
    rvalid = (pend.size() > 0) && (pend[0].due <= cyc);
    rdata  = rvalid ? memw(pend[0].addr) : $urandom;
    #1;
    if (pst || br) chk("req_blocked", {31'b0, req}, 0);
    if (rvalid) void'(pend.pop_front());
    if (req && g) begin
      chk("fetch_addr", addr, exp_fetch);
      exp_fetch += 32'd4;
      pend.push_back('{addr, cyc + lat});
    end
    chk("credit", {31'b0, pend.size() <= FQ}, 1);
    if (br) begin
      exp_pc    = {tgt[31:2], 2'b00};
      exp_fetch = {tgt[31:2], 2'b00};
    end
    last_stall = dst; last_flush = fl;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n, input int lat);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, 1, lat);
  endtask

  initial begin
    int found;
    @(negedge clk);
    do_reset();

    // first-instruction latency
    chk("c0_valid", {31'b0, dvalid}, 0);
    cycle(0, 0, 0, 0, '0, 1, 1);
    chk("c1_valid", {31'b0, dvalid}, 0);
    cycle(0, 0, 0, 0, '0, 1, 1);
    chk("c2_valid", {31'b0, dvalid}, 1);
    chk("c2_pc", dpc, 0);

    // load-use stall at pc 0x8
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dvalid && dpc == 32'h8) found = 1;
      else cycle(0, 0, 0, 0, '0, 1, 1);
    end
    chk("lu_found", found, 1);
    cycle(1, 1, 0, 0, '0, 1, 1);
    chk("lu_hold", dpc, 32'h8);
    cycle(0, 0, 0, 0, '0, 1, 1);
    chk("lu_next", dpc, 32'hC);

    // redirect with stale responses in flight
    run(4, 3);
    cycle(0, 0, 1, 1, 32'h100, 1, 3);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (dvalid) found = 1;
      else cycle(0, 0, 0, 0, '0, 1, 3);
    end
    chk("br_found", found, 1);
    chk("br_pc", dpc, 32'h100);
    chk("br_instr", dinstr, memw(32'h100));

    // grant backpressure at 0x10
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (addr == 32'h10) found = 1;
      else cycle(0, 0, 0, 0, '0, 1, 1);
    end
    chk("bp_found", found, 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_addr", addr, 32'h10);
      cycle(0, 0, 0, 0, '0, 0, 1);
    end
    chk("bp_resume", addr, 32'h10);
    cycle(0, 0, 0, 0, '0, 1, 1);
    chk("bp_next", addr, 32'h14);
    run(4, 1);

    // flush while stalled
    cycle(0, 1, 1, 0, '0, 1, 1);
    chk("fs_valid", {31'b0, dvalid}, 0);
    chk("fs_instr", dinstr, RV32I_NOP);
    run(6, 1);

    // unaligned target, then wrap past the top of memory
    cycle(0, 0, 1, 1, 32'h203, 1, 1);
    chk("unaligned", addr, 32'h200);
    run(5, 1);
    cycle(0, 0, 1, 1, 32'hFFFF_FFFC, 1, 1);
    chk("wrap_top", addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, '0, 1, 1);
    chk("wrap_zero", addr, 32'h0);
    run(6, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic pst, dst, br;
      br  = ($urandom % 25) == 0;
      pst = !br && (($urandom % 10) == 0);
      dst = pst || (($urandom % 12) == 0);
      cycle(pst, dst, br, br, $urandom, ($urandom % 4) != 0, $urandom_range(1, 3));
    end

    // reset in the middle of traffic, then recover
    do_reset();
    run(10, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
